// File: rtl/lif_layer_tdm.sv
// Time-multiplexed leaky integrate-and-fire layer: one saturating accumulator walks every neuron.
// Optional build macro MEM_POT_READBACK_EN: mem_addr[31]=1 reads neuron potentials while idle.

module lif_layer_tdm #(
  parameter int unsigned                     WEIGHT_SIZE       = 32,
  parameter int unsigned                     NUM_INPUTS        = 4,
  parameter int unsigned                     NUM_NEURONS       = 4,
  parameter int unsigned                     RECURRENT         = 1,
  parameter logic signed [2*WEIGHT_SIZE-1:0] THRESH            = 15,
  parameter logic signed [2*WEIGHT_SIZE-1:0] RESET             = 0,
  parameter int unsigned                     REFRAC            = 5,
  parameter int unsigned                     LEAK_SHIFT        = 4,
  parameter int unsigned                     ADDR_WIDTH        = 32,
  parameter int unsigned                     WEIGHT_ADDR_WIDTH = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   step,
  input  logic [NUM_INPUTS-1:0]  spike_in,
  output logic [NUM_NEURONS-1:0] spike_out,
  output logic                   busy,
  output logic                   done,
  input  logic [ADDR_WIDTH-1:0]  mem_addr,
  input  logic [WEIGHT_SIZE-1:0] mem_din,
  input  logic                   mem_wen,
  output logic [WEIGHT_SIZE-1:0] mem_dout
);

  localparam int unsigned PotW  = 2 * WEIGHT_SIZE;
  localparam int unsigned L     = NUM_INPUTS + ((RECURRENT != 0) ? NUM_NEURONS : 0);
  localparam int unsigned Depth = NUM_NEURONS * L;
  localparam int unsigned NeurW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam int unsigned InW   = (L > 1) ? $clog2(L) : 1;
  localparam int unsigned IdxW  = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned RefW  = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
  localparam int unsigned NSelW = ADDR_WIDTH - 1 - WEIGHT_ADDR_WIDTH;

  localparam logic signed [PotW-1:0] PotMax = {1'b0, {(PotW-1){1'b1}}};
  localparam logic signed [PotW-1:0] PotMin = {1'b1, {(PotW-1){1'b0}}};

  typedef enum logic [2:0] {StIdle, StLeak, StAccum, StFire, StDone} state_e;

  state_e                   state_q, state_d;
  logic [NeurW-1:0]         neur_q, neur_d;
  logic [InW-1:0]           inp_q, inp_d, rd_idx;
  logic [L-1:0]             in_vec_q, in_vec_d, lat_vec;
  logic signed [PotW-1:0]   acc_q, acc_d, v_cur, sat_sum;
  logic signed [PotW:0]     sum_wide;
  logic [WEIGHT_SIZE-1:0]   w_rd_q;
  logic [NUM_NEURONS-1:0]   spk_new_q, spk_new_d, spike_out_q, spike_out_d;
  logic                     done_q, done_d;
  logic [WEIGHT_SIZE-1:0]   mem_dout_q, mem_dout_d;
  logic signed [PotW-1:0]   v_q [NUM_NEURONS];
  logic signed [PotW-1:0]   v_d [NUM_NEURONS];
  logic [RefW-1:0]          ref_q [NUM_NEURONS];
  logic [RefW-1:0]          ref_d [NUM_NEURONS];
  logic                     refractory;
  logic [IdxW-1:0]          dp_flat;
  logic [WEIGHT_SIZE-1:0]   wmem_q [Depth];

  // Host address decode
  logic                         addr_msb, neur_ok, addr_hit;
  logic [NSelW-1:0]             addr_neur;
  logic [WEIGHT_ADDR_WIDTH-1:0] addr_in;
  logic [IdxW-1:0]              addr_flat;

  assign addr_msb  = mem_addr[ADDR_WIDTH-1];
  assign addr_neur = mem_addr[ADDR_WIDTH-2:WEIGHT_ADDR_WIDTH];
  assign addr_in   = mem_addr[WEIGHT_ADDR_WIDTH-1:0];
  assign neur_ok   = addr_neur < NSelW'(NUM_NEURONS);
  assign addr_hit  = !addr_msb && neur_ok && (addr_in < WEIGHT_ADDR_WIDTH'(L));
  assign addr_flat = IdxW'(NeurW'(addr_neur)) * IdxW'(L) + IdxW'(addr_in);

  // Feedback bits sit above the external inputs in the latched vector
  if (RECURRENT != 0) begin : g_rec
    assign lat_vec = {spike_out_q, spike_in};
  end else begin : g_norec
    assign lat_vec = spike_in;
  end

  assign v_cur      = v_q[neur_q];
  assign refractory = ref_q[neur_q] != '0;

  assign sum_wide = {acc_q[PotW-1], acc_q} +
                    {{(WEIGHT_SIZE+1){w_rd_q[WEIGHT_SIZE-1]}}, w_rd_q};
  assign sat_sum  = (sum_wide[PotW] != sum_wide[PotW-1]) ?
                    (sum_wide[PotW] ? PotMin : PotMax) : sum_wide[PotW-1:0];

  // Weight for input k+1 is fetched while input k is being accumulated
  assign rd_idx  = (state_q == StAccum && inp_q != InW'(L - 1)) ? inp_q + InW'(1) : '0;
  assign dp_flat = IdxW'(neur_q) * IdxW'(L) + IdxW'(rd_idx);

  always_comb begin
    state_d     = state_q;
    neur_d      = neur_q;
    inp_d       = inp_q;
    in_vec_d    = in_vec_q;
    acc_d       = acc_q;
    spk_new_d   = spk_new_q;
    spike_out_d = spike_out_q;
    done_d      = 1'b0;
    v_d         = v_q;
    ref_d       = ref_q;

    unique case (state_q)
      StIdle: begin
        if (step) begin
          in_vec_d = lat_vec;
          neur_d   = '0;
          state_d  = StLeak;
        end
      end
      StLeak: begin
        inp_d = '0;
        acc_d = v_cur;
        if (!refractory && LEAK_SHIFT != 0) acc_d = v_cur - (v_cur >>> LEAK_SHIFT);
        state_d = StAccum;
      end
      StAccum: begin
        // Refractory neurons still spend L cycles here so latency stays fixed
        if (!refractory && in_vec_q[inp_q]) acc_d = sat_sum;
        if (inp_q == InW'(L - 1)) begin
          state_d = StFire;
        end else begin
          inp_d = inp_q + InW'(1);
        end
      end
      StFire: begin
        if (refractory) begin
          ref_d[neur_q]     = ref_q[neur_q] - RefW'(1);
          v_d[neur_q]       = RESET;
          spk_new_d[neur_q] = 1'b0;
        end else if (acc_q >= THRESH) begin
          ref_d[neur_q]     = RefW'(REFRAC);
          v_d[neur_q]       = RESET;
          spk_new_d[neur_q] = 1'b1;
        end else begin
          v_d[neur_q]       = acc_q;
          spk_new_d[neur_q] = 1'b0;
        end
        if (neur_q == NeurW'(NUM_NEURONS - 1)) begin
          state_d = StDone;
        end else begin
          neur_d  = neur_q + NeurW'(1);
          state_d = StLeak;
        end
      end
      StDone: begin
        spike_out_d = spk_new_q;
        done_d      = 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mem_dout_d = mem_dout_q;
    if (state_q == StIdle) begin
      mem_dout_d = '0;
      if (addr_hit) begin
        mem_dout_d = wmem_q[addr_flat];
      end
`ifdef MEM_POT_READBACK_EN
      else if (addr_msb && neur_ok) begin
        mem_dout_d = v_q[NeurW'(addr_neur)][WEIGHT_SIZE-1:0];
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      neur_q      <= '0;
      inp_q       <= '0;
      in_vec_q    <= '0;
      acc_q       <= '0;
      spk_new_q   <= '0;
      spike_out_q <= '0;
      done_q      <= 1'b0;
      mem_dout_q  <= '0;
      v_q         <= '{default: RESET};
      ref_q       <= '{default: '0};
    end else begin
      state_q     <= state_d;
      neur_q      <= neur_d;
      inp_q       <= inp_d;
      in_vec_q    <= in_vec_d;
      acc_q       <= acc_d;
      spk_new_q   <= spk_new_d;
      spike_out_q <= spike_out_d;
      done_q      <= done_d;
      mem_dout_q  <= mem_dout_d;
      v_q         <= v_d;
      ref_q       <= ref_d;
    end
  end

  // Weight RAM keeps its contents across reset
  always_ff @(posedge clk) begin
    if (mem_wen && state_q == StIdle && addr_hit) wmem_q[addr_flat] <= mem_din;
    w_rd_q <= wmem_q[dp_flat];
  end

  assign spike_out = spike_out_q;
  assign busy      = state_q != StIdle;
  assign done      = done_q;
  assign mem_dout  = mem_dout_q;

endmodule

// File: tb/tb_lif_layer_tdm.sv
// Directed bench for lif_layer_tdm: default layer plus a narrow saturation instance.

module tb_lif_layer_tdm;

  logic        clk, rst;
  logic        step, busy, done, mem_wen;
  logic [3:0]  spike_in, spike_out;
  logic [31:0] mem_addr, mem_din, mem_dout;

  logic        step_s, busy_s, done_s, mem_wen_s;
  logic [3:0]  spike_in_s;
  logic [1:0]  spike_out_s;
  logic [31:0] mem_addr_s;
  logic [7:0]  mem_din_s, mem_dout_s;

  int n_cmp = 0;
  int n_err = 0;

  lif_layer_tdm u_dut (
    .clk      (clk),
    .rst      (rst),
    .step     (step),
    .spike_in (spike_in),
    .spike_out(spike_out),
    .busy     (busy),
    .done     (done),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_wen  (mem_wen),
    .mem_dout (mem_dout)
  );

  lif_layer_tdm #(
    .WEIGHT_SIZE(8),
    .NUM_INPUTS (4),
    .NUM_NEURONS(2),
    .RECURRENT  (0),
    .THRESH     (16'sh7FFF),
    .RESET      (16'sh0000),
    .REFRAC     (0),
    .LEAK_SHIFT (0)
  ) u_dut_sat (
    .clk      (clk),
    .rst      (rst),
    .step     (step_s),
    .spike_in (spike_in_s),
    .spike_out(spike_out_s),
    .busy     (busy_s),
    .done     (done_s),
    .mem_addr (mem_addr_s),
    .mem_din  (mem_din_s),
    .mem_wen  (mem_wen_s),
    .mem_dout (mem_dout_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] waddr(input int n, input int i);
    return {1'b0, 21'(n), 10'(i)};
  endfunction

  task automatic wr(input int n, input int i, input logic [31:0] d);
    mem_addr = waddr(n, i);
    mem_din  = d;
    mem_wen  = 1'b1;
    @(posedge clk); #1;
    mem_wen  = 1'b0;
  endtask

  task automatic rd(input int n, input int i, output logic [31:0] d);
    mem_addr = waddr(n, i);
    @(posedge clk); #1;
    d = mem_dout;
  endtask

  task automatic wr_s(input int n, input int i, input logic [7:0] d);
    mem_addr_s = waddr(n, i);
    mem_din_s  = d;
    mem_wen_s  = 1'b1;
    @(posedge clk); #1;
    mem_wen_s  = 1'b0;
  endtask

  // Returns edges from step acceptance until done is seen (200 means timeout)
  task automatic run_step(input logic [3:0] si, output int lat);
    spike_in = si;
    step     = 1'b1;
    @(posedge clk); #1;
    step     = 1'b0;
    spike_in = ~si;
    lat      = 0;
    while (done !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_step_s(input logic [3:0] si, output int lat);
    spike_in_s = si;
    step_s     = 1'b1;
    @(posedge clk); #1;
    step_s     = 1'b0;
    lat        = 0;
    while (done_s !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected summary");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [3:0]  si_tab  [10];
    logic [3:0]  exp_tab [10];
    int          lat, n_done, first_done;

    si_tab  = '{4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0001,
                4'b0001, 4'b0001, 4'b0001, 4'b0100, 4'b1000};
    exp_tab = '{4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0000,
                4'b0000, 4'b0001, 4'b0010, 4'b0000, 4'b0100};

    step = 0; spike_in = 0; mem_addr = 0; mem_din = 0; mem_wen = 0;
    step_s = 0; spike_in_s = 0; mem_addr_s = 0; mem_din_s = 0; mem_wen_s = 0;
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_spike_out", spike_out, 4'b0000);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_done", done, 1'b0);
    check_val("rst_mem_dout", mem_dout, 32'd0);
    rst = 1'b1;

    for (int n = 0; n < 4; n++) for (int i = 0; i < 8; i++) wr(n, i, 32'd0);
    for (int n = 0; n < 2; n++) for (int i = 0; i < 4; i++) wr_s(n, i, 8'd0);

    // Memory port: readback, out-of-range writes/reads, reserved bit
    wr(0, 0, 32'd16);
    rd(0, 0, d);  check_val("rd_w00", d, 32'd16);
    wr(4, 0, 32'h55);
    rd(4, 0, d);  check_val("rd_neur_oor", d, 32'd0);
    wr(0, 8, 32'h66);
    rd(0, 8, d);  check_val("rd_in_oor", d, 32'd0);
    rd(1, 0, d);  check_val("rd_no_alias", d, 32'd0);
    mem_addr = 32'h8000_0000;
    @(posedge clk); #1;
    check_val("rd_bit31", mem_dout, 32'd0);

    wr(1, 4, 32'd16);
    wr(2, 2, 32'hFFFF_FFE0);
    wr(2, 3, 32'd45);
    wr(3, 2, 32'd14);

    // Saturation: +508 per step, clamps to 32767 in step 65 and fires at THRESH=max
    for (int i = 0; i < 4; i++) wr_s(0, i, 8'h7F);
    for (int k = 1; k <= 66; k++) begin
      run_step_s(4'b1111, lat);
      check_val($sformatf("sat_lat%0d", k), lat, 13);
      check_val($sformatf("sat_spk%0d", k), spike_out_s, (k == 65) ? 2'b01 : 2'b00);
    end

    // Fire, refractory, recurrent feedback and leak/threshold sequence
    for (int s = 0; s < 10; s++) begin
      run_step(si_tab[s], lat);
      check_val($sformatf("lat_s%0d", s + 1), lat, 41);
      check_val($sformatf("spk_s%0d", s + 1), spike_out, exp_tab[s]);
      check_val($sformatf("busy_s%0d", s + 1), busy, 1'b0);
    end

    // Reset in the middle of accumulation
    spike_in = 4'b0001;
    step     = 1'b1;
    @(posedge clk); #1;
    step     = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check_val("midrst_spike_out", spike_out, 4'b0000);
    check_val("midrst_busy", busy, 1'b0);
    check_val("midrst_done", done, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    rd(0, 0, d);  check_val("keep_w00", d, 32'd16);
    rd(2, 3, d);  check_val("keep_w23", d, 32'd45);

    // Writes and steps while busy are dropped; read data holds
    check_val("dout_pre", mem_dout, 32'd45);
    rd(0, 0, d);  check_val("dout_pre2", d, 32'd16);
    spike_in = 4'b0001;
    step     = 1'b1;
    @(posedge clk); #1;
    step       = 1'b0;
    n_done     = 0;
    first_done = 0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        n_done++;
        if (first_done == 0) first_done = c;
      end
      mem_wen = 1'b0;
      step    = 1'b0;
      if (c == 1) check_val("busy_mid", busy, 1'b1);
      if (c == 3) begin
        mem_addr = waddr(0, 0);
        mem_din  = 32'd0;
        mem_wen  = 1'b1;
      end
      if (c == 5) step = 1'b1;
      if (c == 7) mem_addr = waddr(2, 2);
      if (c == 9) check_val("dout_hold", mem_dout, 32'd16);
    end
    check_val("busy_done_count", n_done, 1);
    check_val("busy_done_lat", first_done, 41);
    check_val("post_rst_spk", spike_out, 4'b0001);
    check_val("post_rst_busy", busy, 1'b0);
    rd(0, 0, d);  check_val("busy_wr_dropped", d, 32'd16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
